hazard_fwd_unit: RTL

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline. It drives the 2-bit select inputs of the two EX-stage operand 3-to-1 muxes, and it asserts a one-cycle load-use stall. It also counts stall cycles for performance debug.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/hazard_shadow_stage.sv | 30 +++
 rtl/hazard_fwd_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: forwarding mux selects and shadow-stage records
// used by the hazard/forwarding controller.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } stage_info_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic                  mem_read;
    } ex_src_t;

    // A producing stage can feed a source only if it really writes a nonzero register.
    function automatic logic fwd_match(input stage_info_t s,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic used);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == src) & used;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline stage: captures the incoming stage record when load is
// high, otherwise turns into a bubble.
module hazard_shadow_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  stage_info_t info_in,
    output stage_info_t info_out
);

    stage_info_t info_d;
    stage_info_t info_q;

    always_comb begin
        info_d = load ? info_in : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            info_q <= '0;
        end else begin
            info_q <= info_d;
        end
    end

    assign info_out = info_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and EX operand forwarding for the 5-stage MIPS core,
// driven by a shadow copy of the EX/MEM/WB destination registers.
module hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic [CNT_W-1:0]      stall_count
);

    stage_info_t      ex_info_d;
    stage_info_t      ex_info_q;
    stage_info_t      mem_info_q;
    stage_info_t      wb_info_q;
    ex_src_t          ex_src_d;
    ex_src_t          ex_src_q;
    logic             ex_load;
    logic             load_use;
    fwd_sel_e         fwd_a;
    fwd_sel_e         fwd_b;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] stall_count_q;

    // Flush wins over stall, so a squashed instruction can never hold the front end.
    assign load_use = id_valid & ~flush & ex_info_q.valid & ex_src_q.mem_read
                    & (ex_info_q.rd != '0)
                    & ((id_use_rs & (id_rs == ex_info_q.rd)) |
                       (id_use_rt & (id_rt == ex_info_q.rd)));

    assign ex_load = id_valid & ~load_use & ~flush;

    always_comb begin
        ex_info_d.valid     = 1'b1;
        ex_info_d.rd        = id_rd;
        ex_info_d.reg_write = id_reg_write;
        ex_src_d            = '0;
        if (ex_load) begin
            ex_src_d.rs       = id_rs;
            ex_src_d.rt       = id_rt;
            ex_src_d.use_rs   = id_use_rs;
            ex_src_d.use_rt   = id_use_rt;
            ex_src_d.mem_read = id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_src_q <= '0;
        end else begin
            ex_src_q <= ex_src_d;
        end
    end

    hazard_shadow_stage u_ex_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (ex_load),
        .info_in  (ex_info_d),
        .info_out (ex_info_q)
    );

    hazard_shadow_stage u_mem_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .info_in  (ex_info_q),
        .info_out (mem_info_q)
    );

    hazard_shadow_stage u_wb_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .info_in  (mem_info_q),
        .info_out (wb_info_q)
    );

    // MEM is the younger producer, so it outranks WB when both match.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (ex_info_q.valid) begin
            if (fwd_match(mem_info_q, ex_src_q.rs, ex_src_q.use_rs)) begin
                fwd_a = FWD_MEM;
            end else if (fwd_match(wb_info_q, ex_src_q.rs, ex_src_q.use_rs)) begin
                fwd_a = FWD_WB;
            end
            if (fwd_match(mem_info_q, ex_src_q.rt, ex_src_q.use_rt)) begin
                fwd_b = FWD_MEM;
            end else if (fwd_match(wb_info_q, ex_src_q.rt, ex_src_q.use_rt)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (load_use && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_a_sel     = fwd_a;
    assign fwd_b_sel     = fwd_b;
    assign stall         = load_use;
    assign pc_write_en   = ~load_use;
    assign ifid_write_en = ~load_use;
    assign stall_count   = stall_count_q;

endmodule
